aes_mem_ctrl: RTL and testbench
===============================

AES_MEM_CTRL -- requirements
Module: aes_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max WAIT-state cycles before abort (used only with AES_MEM_CTRL_TIMEOUT_EN).
REQ-002 SHALL have parameter CNT_W, default 16, width of block count/counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port go  input  1  start a run; sampled only in IDLE.
REQ-006 SHALL have port nblocks  input  CNT_W  number of 128-bit blocks to process; latched when go is accepted.
REQ-007 SHALL have port mem_ren  output  1  one-cycle pulse advancing memory read pointer by 4 rows.
REQ-008 SHALL have ports rd_row0..rd_row3  input  32 each  current memory rows (combinational from memory).
REQ-009 SHALL have port mem_wen  output  1  one-cycle write strobe.
REQ-010 SHALL have ports wr_row0..wr_row3  output  32 each  result rows to memory.
REQ-011 SHALL have port core_start  output  1  one-cycle pulse starting AES core.
REQ-012 SHALL have port core_din  output  128  block to core, {row0,row1,row2,row3}, row0 in [127:96].
REQ-013 SHALL have port core_done  input  1  core result valid; honoured only in WAIT.
REQ-014 SHALL have port core_dout  input  128  core result, same row order as core_din.
REQ-015 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), err  output  1 (sticky until next accepted go), blk_cnt  output  CNT_W (blocks written this run).

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, START, WAIT, WRITE, FIN.
REQ-017 IDLE: go=1 and nblocks!=0 -> latch nblocks, clear blk_cnt and err, go to FETCH; go=1 and nblocks=0 -> go to FIN (no memory/core activity); else stay.
REQ-018 FETCH: register rd_row0..3 into core_din, assert mem_ren for exactly this cycle, -> START.
REQ-019 START: assert core_start for exactly this cycle, -> WAIT.
REQ-020 WAIT: core_done=1 -> register core_dout into wr_row0..3, -> WRITE; else stay.
REQ-021 WRITE: assert mem_wen this cycle with stable wr_row0..3; blk_cnt increments at end of cycle; if incremented value equals latched nblocks -> FIN, else -> FETCH.
REQ-022 FIN: assert done for exactly this cycle, -> IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 go while busy SHALL be ignored; nblocks changes after latch SHALL have no effect.
REQ-025 core_done outside WAIT SHALL be ignored.
REQ-026 Minimum per-block period SHALL be 4 cycles (FETCH, START, one WAIT, WRITE).
REQ-027 blk_cnt SHALL hold its final value after FIN until the next accepted go.

Reset
REQ-028 rst=1 SHALL force IDLE immediately, including mid-run, without completing a pending write.
REQ-029 Reset values: mem_ren=0, mem_wen=0, core_start=0, done=0, busy=0, err=0, blk_cnt=0, core_din=0, wr_row0..3=0.

Configuration
REQ-030 With AES_MEM_CTRL_TIMEOUT_EN defined, a WAIT cycle counter (cleared on WAIT entry) SHALL, on reaching TIMEOUT without core_done, set err=1 and go to FIN, skipping WRITE and remaining blocks.
REQ-031 Without AES_MEM_CTRL_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL wait indefinitely, and err SHALL be constant 0.

Verification
REQ-032 Reset then go=1, nblocks=1, rows 00112233/44556677/8899aabb/ccddeeff; core_done 1 cycle after core_start with dout ~din -> core_din=00112233445566778899aabbccddeeff, mem_wen once with wr_row0=ffeeddcc, done pulse, blk_cnt=1.
REQ-033 nblocks=3, core_done on first WAIT cycle -> 3 mem_ren, 3 core_start, 3 mem_wen, FETCH-to-FETCH spacing 4 cycles, done 13 cycles after go accepted.
REQ-034 go=1, nblocks=0 -> done pulse 1 cycle later, no mem_ren/core_start/mem_wen, blk_cnt=0.
REQ-035 go and core_done pulsed repeatedly during a nblocks=2 run and in IDLE -> no extra strobes, blk_cnt=2.
REQ-036 rst asserted in WAIT of block 2 of 4 -> all outputs at reset values next edge, no mem_wen, new go restarts with blk_cnt=0.
REQ-037 With AES_MEM_CTRL_TIMEOUT_EN, TIMEOUT=8, core_done never asserted -> err=1 and done pulse after 8 WAIT cycles, no mem_wen; without macro, busy stays 1 for 1000 cycles.

Source files
------------

// File: rtl/aes_mem_ctrl.sv
// ---------------------------------------------------------------------------
// aes_mem_ctrl
// Streams 128-bit blocks from a row-organised memory through an AES core and
// writes each result back. One block per FETCH/START/WAIT/WRITE round trip.
//
// Optional feature macro: AES_MEM_CTRL_TIMEOUT_EN
//   When defined, a WAIT-state watchdog aborts the run after TIMEOUT cycles
//   without core_done, setting err. When undefined, WAIT waits forever and
//   err is tied low.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   go, nblocks           run request and block count (sampled in IDLE only)
//   mem_ren               pulse: memory read pointer advances by 4 rows
//   rd_row0..3            current memory rows (combinational from memory)
//   mem_wen, wr_row0..3   write strobe and result rows
//   core_start, core_din  core start pulse and input block {row0..row3}
//   core_done, core_dout  core result handshake (honoured only in WAIT)
//   busy, done, err       status: not-IDLE, end-of-run pulse, sticky abort
//   blk_cnt               blocks written in the current/last run
// ---------------------------------------------------------------------------
module aes_mem_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [CNT_W-1:0] nblocks,
   output logic             mem_ren,
   input  logic [31:0]      rd_row0,
   input  logic [31:0]      rd_row1,
   input  logic [31:0]      rd_row2,
   input  logic [31:0]      rd_row3,
   output logic             mem_wen,
   output logic [31:0]      wr_row0,
   output logic [31:0]      wr_row1,
   output logic [31:0]      wr_row2,
   output logic [31:0]      wr_row3,
   output logic             core_start,
   output logic [127:0]     core_din,
   input  logic             core_done,
   input  logic [127:0]     core_dout,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] blk_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_START, S_WAIT, S_WRITE, S_FIN
   } state_t;

   state_t             r_state, w_next;
   logic [CNT_W-1:0]   r_nblocks;
   logic [CNT_W-1:0]   r_blk_cnt;
   logic [CNT_W-1:0]   w_blk_inc;
   logic [127:0]       r_core_din;
   logic [127:0]       r_wr;
   logic               w_accept;

   assign w_blk_inc = r_blk_cnt + 1'b1;
   assign w_accept  = (r_state == S_IDLE) && go;

`ifdef AES_MEM_CTRL_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [TO_W-1:0] r_wait_cnt;
   logic            r_err;
   logic            w_timeout;

   // Counter holds the number of WAIT cycles already completed, so the
   // TIMEOUT-th WAIT cycle is the one that sees TIMEOUT-1.
   assign w_timeout = (r_wait_cnt == TO_W'(TIMEOUT - 1));
   assign err       = r_err;
`else
   assign err       = 1'b0;
`endif

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (go) w_next = (nblocks != '0) ? S_FETCH : S_FIN;
         S_FETCH: w_next = S_START;
         S_START: w_next = S_WAIT;
         S_WAIT: begin
            if (core_done) w_next = S_WRITE;
`ifdef AES_MEM_CTRL_TIMEOUT_EN
            else if (w_timeout) w_next = S_FIN;
`endif
         end
         S_WRITE: w_next = (w_blk_inc == r_nblocks) ? S_FIN : S_FETCH;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nblocks  <= '0;
         r_blk_cnt  <= '0;
         r_core_din <= '0;
         r_wr       <= '0;
      end else begin
         // Any accepted go (including nblocks=0) starts a fresh count.
         if (w_accept) begin
            r_nblocks <= nblocks;
            r_blk_cnt <= '0;
         end
         if (r_state == S_FETCH)
            r_core_din <= {rd_row0, rd_row1, rd_row2, rd_row3};
         if ((r_state == S_WAIT) && core_done)
            r_wr <= core_dout;
         if (r_state == S_WRITE)
            r_blk_cnt <= w_blk_inc;
      end
   end

`ifdef AES_MEM_CTRL_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_accept)                 r_err      <= 1'b0;
         if (r_state == S_START)       r_wait_cnt <= '0;
         else if (r_state == S_WAIT)   r_wait_cnt <= r_wait_cnt + 1'b1;
         if ((r_state == S_WAIT) && !core_done && w_timeout)
            r_err <= 1'b1;
      end
   end
`endif

   // ---------------- outputs ----------------
   // Strobes decode straight from the state register: each state lasts one
   // cycle except WAIT/IDLE, so every strobe is naturally a single pulse.
   assign mem_ren    = (r_state == S_FETCH);
   assign core_start = (r_state == S_START);
   assign mem_wen    = (r_state == S_WRITE);
   assign done       = (r_state == S_FIN);
   assign busy       = (r_state != S_IDLE);
   assign blk_cnt    = r_blk_cnt;
   assign core_din   = r_core_din;
   assign wr_row0    = r_wr[127:96];
   assign wr_row1    = r_wr[95:64];
   assign wr_row2    = r_wr[63:32];
   assign wr_row3    = r_wr[31:0];

endmodule

// File: tb/tb_aes_mem_ctrl.sv
module tb_aes_mem_ctrl;
   localparam int CNT_W = 16;
`ifdef AES_MEM_CTRL_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic clk = 1'b0;
   logic rst, go;
   logic [CNT_W-1:0] nblocks;
   logic [31:0] rd_row0, rd_row1, rd_row2, rd_row3;
   logic [31:0] wr_row0, wr_row1, wr_row2, wr_row3;
   logic mem_ren, mem_wen, core_start, core_done, busy, done, err;
   logic [127:0] core_din, core_dout;
   logic [CNT_W-1:0] blk_cnt;

   aes_mem_ctrl #(.TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .go(go), .nblocks(nblocks),
      .mem_ren(mem_ren), .rd_row0(rd_row0), .rd_row1(rd_row1),
      .rd_row2(rd_row2), .rd_row3(rd_row3),
      .mem_wen(mem_wen), .wr_row0(wr_row0), .wr_row1(wr_row1),
      .wr_row2(wr_row2), .wr_row3(wr_row3),
      .core_start(core_start), .core_din(core_din),
      .core_done(core_done), .core_dout(core_dout),
      .busy(busy), .done(done), .err(err), .blk_cnt(blk_cnt));

   always #5 clk = ~clk;

   int vectors = 0;
   int fails   = 0;

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bad(input string tag);
      vectors++;
      fails++;
      $error("FAIL %s: observed missing-event expected event", tag);
   endtask

   // ---------------- memory model: 256 rows, pointer steps by 4 ----------------
   logic [31:0] mem [256];
   logic [7:0]  ptr;
   assign rd_row0 = mem[ptr];
   assign rd_row1 = mem[8'(ptr + 8'd1)];
   assign rd_row2 = mem[8'(ptr + 8'd2)];
   assign rd_row3 = mem[8'(ptr + 8'd3)];
   always @(posedge clk or posedge rst) begin
      if (rst)          ptr <= 8'd0;
      else if (mem_ren) ptr <= ptr + 8'd4;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- core model: result = input ^ key after lat cycles ----------------
   int           lat  = 1;     // 0 = never answers
   bit           spur = 1'b0;  // random core_done when no request is pending
   bit [127:0]   key  = '1;
   bit           pend = 1'b0;
   int           wleft;
   bit [127:0]   cap;
   always @(negedge clk) begin
      core_done = 1'b0;
      core_dout = {$urandom, $urandom, $urandom, $urandom};
      if (rst) pend = 1'b0;
      else if (core_start) begin
         cap = core_din; pend = (lat > 0); wleft = lat;
      end else if (pend) begin
         wleft--;
         if (wleft == 0) begin core_done = 1'b1; core_dout = cap ^ key; pend = 1'b0; end
      end else if (spur && $urandom_range(0, 1) == 1) core_done = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   int n_ren, n_start, n_wen, n_done;
   int ren_cyc[$];
   logic [127:0] exp_din[$], exp_out[$];
   always @(negedge clk) if (!rst) begin
      if (mem_ren) begin n_ren++; ren_cyc.push_back(cyc); end
      if (core_start) begin
         n_start++;
         if (exp_din.size() > 0) chk("core_din", core_din, exp_din.pop_front());
         else bad("extra_core_start");
      end
      if (mem_wen) begin
         n_wen++;
         if (exp_out.size() > 0) chk("wr_rows", {wr_row0, wr_row1, wr_row2, wr_row3}, exp_out.pop_front());
         else bad("extra_mem_wen");
      end
      if (done) n_done++;
   end

   // Expected traffic of a run follows directly from memory contents at the
   // current pointer: block b = rows ptr+4b..ptr+4b+3, result = block ^ key.
   task automatic prep(input int n, input bit [127:0] k, input int l, input bit sp);
      logic [7:0]   a;
      logic [127:0] blk;
      n_ren = 0; n_start = 0; n_wen = 0; n_done = 0;
      ren_cyc.delete(); exp_din.delete(); exp_out.delete();
      key = k; lat = l; spur = sp;
      for (int b = 0; b < n; b++) begin
         a   = 8'(ptr + 8'(4 * b));
         blk = {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
         exp_din.push_back(blk);
         exp_out.push_back(blk ^ k);
      end
   endtask

   // Issue go, wait for done; returns cycles from go-cycle to done-cycle.
   task automatic run(input int n, input bit jitter, output int k);
      bit got = 1'b0;
      @(negedge clk); go = 1'b1; nblocks = CNT_W'(n);
      k = 0;
      while (!got && k < 300) begin
         @(negedge clk); k++;
         if (k == 1) chk("blk_cnt_cleared", blk_cnt, 0);
         if (done) got = 1'b1;
         go      = (!got && jitter) ? 1'($urandom_range(0, 1)) : 1'b0;
         nblocks = jitter ? CNT_W'($urandom) : nblocks;
      end
      go = 1'b0;
      if (!got) bad("done_timeout");
      @(negedge clk);
   endtask

   task automatic chk_counts(input string tag, input int n);
      chk({tag, "_ren"},   n_ren, n);
      chk({tag, "_start"}, n_start, n);
      chk({tag, "_wen"},   n_wen, n);
      chk({tag, "_done"},  n_done, 1);
      chk({tag, "_blk"},   blk_cnt, n);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_err"},   err, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, {busy, done, mem_ren, mem_wen, core_start, err}, 6'b0);
      chk({tag, "_blk"}, blk_cnt, 0);
      chk({tag, "_din"}, core_din, 0);
      chk({tag, "_wr"},  {wr_row0, wr_row1, wr_row2, wr_row3}, 0);
   endtask

   initial begin
      int k;
      rst = 1'b1; go = 1'b0; nblocks = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h00112233; mem[1] = 32'h44556677;
      mem[2] = 32'h8899aabb; mem[3] = 32'hccddeeff;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      // Single block, known vector, core inverts its input.
      prep(1, '1, 1, 1'b0);
      run(1, 1'b0, k);
      chk_counts("one", 1);
      chk("one_core_din", core_din, 128'h00112233445566778899aabbccddeeff);
      chk("one_wr_row0", wr_row0, 32'hffeeddcc);
      chk("one_latency", k, 5);

      // Three blocks back to back at the minimum block period.
      prep(3, {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
      run(3, 1'b0, k);
      chk_counts("three", 3);
      chk("three_latency", k, 13);
      for (int i = 1; i < ren_cyc.size(); i++) chk("fetch_spacing", ren_cyc[i] - ren_cyc[i-1], 4);

      // Zero blocks: done only, counter cleared from previous run.
      prep(0, '1, 1, 1'b0);
      run(0, 1'b0, k);
      chk_counts("zero", 0);
      chk("zero_latency", k, 1);

      // Stray go / core_done / nblocks activity during a run and in IDLE.
      prep(2, {$urandom, $urandom, $urandom, $urandom}, 3, 1'b1);
      run(2, 1'b1, k);
      chk_counts("noise", 2);
      n_done = 0;
      repeat (10) @(negedge clk);
      chk("idle_noise", {n_ren, n_start, n_wen, n_done, 1'(busy)}, {32'd2, 32'd2, 32'd2, 32'd0, 1'b0});
      spur = 1'b0;

      // Randomized runs.
      for (int it = 0; it < 5; it++) begin
         int n = $urandom_range(1, 5);
         prep(n, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 4), 1'b1);
         run(n, 1'b1, k);
         chk_counts("rand", n);
         chk("rand_drain", exp_out.size(), 0);
      end
      spur = 1'b0;

      // Reset while waiting on block 2 of 4.
      prep(4, '1, 30, 1'b0);
      @(negedge clk); go = 1'b1; nblocks = 16'd4;
      @(negedge clk); go = 1'b0;
      k = 0;
      while (n_start < 2 && k < 100) begin @(negedge clk); k++; end
      if (n_start < 2) bad("second_start_timeout");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset("midrun_reset");
      chk("midrun_wen", n_wen, 1);
      rst = 1'b0;
      prep(2, {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0);
      run(2, 1'b0, k);
      chk_counts("restart", 2);

`ifdef AES_MEM_CTRL_TIMEOUT_EN
      // Core never answers: abort after TMO WAIT cycles.
      prep(3, '1, 0, 1'b0);
      run(3, 1'b0, k);
      chk("tmo_latency", k, 2 + TMO + 1);
      chk("tmo_err", err, 1);
      chk("tmo_wen", n_wen, 0);
      chk("tmo_start", n_start, 1);
      chk("tmo_blk", blk_cnt, 0);
      prep(1, '1, 1, 1'b0);
      run(1, 1'b0, k);
      chk_counts("after_tmo", 1);
`else
      // Core never answers: controller waits indefinitely.
      prep(1, '1, 0, 1'b0);
      @(negedge clk); go = 1'b1; nblocks = 16'd1;
      @(negedge clk); go = 1'b0;
      repeat (1000) @(negedge clk);
      chk("hang_busy", {1'(busy), 1'(err)}, 2'b10);
      chk("hang_done", {n_done, n_wen}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset("hang_reset");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
